sprite_table_write_buffer: RTL and testbench
============================================

SPRITE_TABLE_WRITE_BUFFER -- requirements
Module: sprite_table_write_buffer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1080_0000, sprite table window base (2 KB aligned).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, write-buffer entries (power of 2, 2..32).
REQ-003 SHALL have parameter VBLANK_ROW, default 12'd480, first pix_row value that counts as vertical blank.
REQ-004 clk  in  1  pixel clock (25 MHz); one clock only.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 HADDR  in  32  AHB address, address phase.
REQ-007 HWDATA  in  32  AHB write data, data phase.
REQ-008 HWRITE  in  1  AHB write qualifier, address phase.
REQ-009 HTRANS  in  2  AHB transfer type.
REQ-010 pix_row  in  12  current display row from the timing generator.
REQ-011 sprite_table_wr  out  1  one-cycle write strobe to the sprite manager.
REQ-012 sprite_table_addr  out  9  sprite table word address.
REQ-013 sprite_table_di  out  32  sprite table write data.
REQ-014 fifo_level  out  $clog2(FIFO_DEPTH)+1  current buffered entry count.
REQ-015 overflow  out  1  sticky: a write was dropped.

Function
REQ-016 Address phase SHALL hit when HTRANS is NONSEQ (2'b10) or SEQ (2'b11), HWRITE=1, HADDR[31:11]==BASE_ADDR[31:11]; IDLE/BUSY never hit.
REQ-017 On hit, HADDR[10:2] SHALL be registered with a pending flag; HWDATA SHALL be sampled on the following clock (data phase), forming one entry.
REQ-018 Back-to-back hits on consecutive cycles SHALL each produce an entry (address capture of N+1 overlaps data capture of N); no wait states inserted, bus never stalled.
REQ-019 An entry SHALL be pushed into the FIFO at the end of its data-phase cycle (hit in cycle N -> entry counted in fifo_level in cycle N+2).
REQ-020 Drain: while pix_row >= VBLANK_ROW and FIFO not empty, SHALL pop one entry per clock, driving sprite_table_wr=1 with its addr/data for exactly that cycle, in FIFO order.
REQ-021 Outside vblank SHALL hold sprite_table_wr=0; addr/di hold last popped value.
REQ-022 Full FIFO with no pop in same cycle: new entry SHALL be discarded, overflow set to 1 and held until reset.
REQ-023 Simultaneous push and pop when full SHALL accept the push; no overflow; level unchanged.
REQ-024 Simultaneous push and pop when empty SHALL NOT bypass: push stored, pop suppressed that cycle.
REQ-025 pix_row leaving vblank mid-drain SHALL stop popping on the first cycle pix_row < VBLANK_ROW; remaining entries kept.
REQ-026 Read pointers/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level = entries stored, 0..FIFO_DEPTH.

Reset
REQ-027 rst SHALL asynchronously clear: FIFO (level 0), pointers, pending address-phase flag, sprite_table_wr=0, sprite_table_addr=0, sprite_table_di=0, overflow=0.
REQ-028 Reset asserted between address and data phase SHALL discard that transfer; reset mid-drain SHALL discard all remaining entries.
REQ-029 First hit SHALL be recognised on the first rising clk after rst deasserts.

Configuration
REQ-030 Macro SPRITE_WRITE_DEFER_EN defined: deferred behaviour of REQ-019..REQ-026.
REQ-031 SPRITE_WRITE_DEFER_EN undefined: no FIFO; each entry SHALL drive sprite_table_wr=1 in cycle N+2 regardless of pix_row; fifo_level and overflow tied to 0.

Structure
REQ-032 Package sprite_pkg SHALL hold HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), SPRITE_TABLE_AW=9, default VBLANK_ROW.
REQ-033 One sub-module sync_fifo (parameterised width 41, depth FIFO_DEPTH, push/pop/full/empty/level) SHALL hold entries; capture and drain logic in the top.

Verification
REQ-034 Single write HADDR=BASE+0x10, data 0xDEADBEEF at pix_row=100 -> fifo_level=1, no strobe; at pix_row=480 one strobe addr=9'h004 di=0xDEADBEEF.
REQ-035 9 back-to-back NONSEQ/SEQ writes outside vblank, depth 8 -> fifo_level=8, overflow=1, vblank drains exactly 8 in order, 9th absent.
REQ-036 Writes with HTRANS=IDLE, HWRITE=0, or HADDR=BASE+0x800 -> no entry, fifo_level stays 0.
REQ-037 Full FIFO in vblank with concurrent new write -> 8 strobes over 8 cycles then 9th, overflow stays 0.
REQ-038 rst pulsed one cycle after address phase of a hit with 3 entries stored -> fifo_level=0, no strobe ever for those writes, overflow=0.
REQ-039 Build without SPRITE_WRITE_DEFER_EN, write at pix_row=200 -> strobe exactly in cycle N+2, fifo_level=0.

Source files
------------

// File: rtl/sprite_table_write_buffer_pkg.sv
// Shared definitions for the sprite table write buffer: AHB transfer encodings,
// sprite table geometry and the buffered write entry layout.
package sprite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam int          SPRITE_TABLE_AW    = 9;
  localparam int          SPRITE_DATA_W      = 32;
  localparam logic [11:0] DEFAULT_VBLANK_ROW = 12'd480;

  // One buffered write: sprite table word address plus its data word.
  typedef struct packed {
    logic [SPRITE_TABLE_AW-1:0] addr;
    logic [SPRITE_DATA_W-1:0]   data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/sprite_table_write_buffer_sync_fifo.sv
// Single-clock FIFO holding buffered sprite table writes. A push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_table_write_buffer.sv
// AHB write capture into the sprite table. With SPRITE_WRITE_DEFER_EN defined,
// writes are buffered and drained only during vertical blank; otherwise they pass straight through.
module sprite_table_write_buffer
  import sprite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1080_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [11:0] VBLANK_ROW = DEFAULT_VBLANK_ROW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [31:0]                      HADDR,
  input  logic [31:0]                      HWDATA,
  input  logic                             HWRITE,
  input  logic [1:0]                       HTRANS,
  input  logic [11:0]                      pix_row,
  output logic                             sprite_table_wr,
  output logic [SPRITE_TABLE_AW-1:0]       sprite_table_addr,
  output logic [31:0]                      sprite_table_di,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overflow
);

  logic                       addr_hit;
  logic                       pending;
  logic [SPRITE_TABLE_AW-1:0] pending_addr;
  entry_t                     data_entry;

  assign addr_hit   = is_active_trans(HTRANS) && HWRITE &&
                      (HADDR[31:11] == BASE_ADDR[31:11]);
  assign data_entry = '{addr: pending_addr, data: HWDATA};

  // Address phase: remember the word address; the data arrives next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= 1'b0;
      pending_addr <= '0;
    end else begin
      pending <= addr_hit;
      if (addr_hit) begin
        pending_addr <= HADDR[10:2];
      end
    end
  end

`ifdef SPRITE_WRITE_DEFER_EN

  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   in_vblank;
  logic   pop_req;
  logic   drop;
  logic   unused_bits;

  assign in_vblank   = (pix_row >= VBLANK_ROW);
  assign pop_req     = in_vblank && !fifo_empty;
  assign drop        = pending && fifo_full && !pop_req;
  assign unused_bits = ^HADDR[1:0];

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pending),
    .push_data (data_entry),
    .pop       (pop_req),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // A popped entry is presented as a one-cycle strobe; addr/di then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sprite_table_wr   <= 1'b0;
      sprite_table_addr <= '0;
      sprite_table_di   <= '0;
      overflow          <= 1'b0;
    end else begin
      sprite_table_wr <= pop_req;
      if (pop_req) begin
        sprite_table_addr <= head.addr;
        sprite_table_di   <= head.data;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`else

  logic unused_bits;

  assign fifo_level  = '0;
  assign overflow    = 1'b0;
  assign unused_bits = ^{pix_row, HADDR[1:0]};

  // Pass-through: the completed entry is written the cycle after its data phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sprite_table_wr   <= 1'b0;
      sprite_table_addr <= '0;
      sprite_table_di   <= '0;
    end else begin
      sprite_table_wr <= pending;
      if (pending) begin
        sprite_table_addr <= data_entry.addr;
        sprite_table_di   <= data_entry.data;
      end
    end
  end

`endif

endmodule

// File: tb/tb_sprite_table_write_buffer.sv
// Self-checking bench for sprite_table_write_buffer: decode table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_sprite_table_write_buffer;
  import sprite_pkg::*;

  localparam logic [31:0] BASE  = 32'h1080_0000;
  localparam int          DEPTH = 8;
  localparam int          LW    = $clog2(DEPTH) + 1;

  logic        clk;
  logic        rst;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [11:0] pix_row;
  logic        sprite_table_wr;
  logic [8:0]  sprite_table_addr;
  logic [31:0] sprite_table_di;
  logic [LW-1:0] fifo_level;
  logic        overflow;

  sprite_table_write_buffer #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .VBLANK_ROW (12'd480)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .HADDR             (HADDR),
    .HWDATA            (HWDATA),
    .HWRITE            (HWRITE),
    .HTRANS            (HTRANS),
    .pix_row           (pix_row),
    .sprite_table_wr   (sprite_table_wr),
    .sprite_table_addr (sprite_table_addr),
    .sprite_table_di   (sprite_table_di),
    .fifo_level        (fifo_level),
    .overflow          (overflow)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of pending entries and the last strobe shown.
  logic [40:0]   mq[$];
  logic          m_prev_hit;
  logic [8:0]    m_prev_addr;
  logic          m_wr;
  logic [8:0]    m_addr;
  logic [31:0]   m_di;
  logic          m_ovf;

  logic          obs_wr;
  logic [LW-1:0] obs_level;
  logic          obs_ovf;
  logic [40:0]   seen[$];

  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] addr;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] pat(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  task automatic compare(input string name, input logic [40:0] act, input logic [40:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_prev_hit  = 1'b0;
    m_prev_addr = '0;
    m_wr        = 1'b0;
    m_addr      = '0;
    m_di        = '0;
    m_ovf       = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [11:0] row);
    logic pop;
`ifdef SPRITE_WRITE_DEFER_EN
    pop = (row >= 12'd480) && (mq.size() > 0);
    if (pop) begin
      m_wr = 1'b1;
      {m_addr, m_di} = mq.pop_front();
    end else begin
      m_wr = 1'b0;
    end
    if (m_prev_hit) begin
      if (mq.size() >= DEPTH) m_ovf = 1'b1;
      else mq.push_back({m_prev_addr, d});
    end
`else
    pop  = 1'b0;
    m_wr = m_prev_hit || pop;
    if (m_prev_hit) {m_addr, m_di} = {m_prev_addr, d};
    if (row == 12'hFFF) m_wr = m_wr;
`endif
    m_prev_hit  = (tr == 2'b10 || tr == 2'b11) && wr && (a[31:11] == BASE[31:11]);
    m_prev_addr = a[10:2];
  endtask

  task automatic checkOutput();
    compare("wr", sprite_table_wr, m_wr);
    compare("addr", sprite_table_addr, m_addr);
    compare("di", sprite_table_di, m_di);
    compare("level", fifo_level, LW'(mq.size()));
    compare("overflow", overflow, m_ovf);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic applyStimulus(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [11:0] row);
    HTRANS  = tr;
    HWRITE  = wr;
    HADDR   = a;
    HWDATA  = d;
    pix_row = row;
    @(negedge clk);
    checkOutput();
    obs_wr    = sprite_table_wr;
    obs_level = fifo_level;
    obs_ovf   = overflow;
    if (sprite_table_wr) seen.push_back({sprite_table_addr, sprite_table_di});
    model_step(tr, wr, a, d, row);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [11:0] row);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 32'h0, $urandom, row);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    #2;
    compare("rst_wr", sprite_table_wr, 1'b0);
    compare("rst_addr", sprite_table_addr, 9'h0);
    compare("rst_di", sprite_table_di, 32'h0);
    compare("rst_level", fifo_level, '0);
    compare("rst_overflow", overflow, 1'b0);
    model_clear();
    seen.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HTRANS = 2'b00; pix_row = 12'd100;
    model_clear();

    vecs[0] = '{2'b10, 1'b1, BASE + 32'h10,  1'b1};
    vecs[1] = '{2'b11, 1'b1, BASE + 32'h7FC, 1'b1};
    vecs[2] = '{2'b00, 1'b1, BASE + 32'h10,  1'b0};
    vecs[3] = '{2'b01, 1'b1, BASE + 32'h10,  1'b0};
    vecs[4] = '{2'b10, 1'b0, BASE + 32'h10,  1'b0};
    vecs[5] = '{2'b10, 1'b1, BASE + 32'h800, 1'b0};
    vecs[6] = '{2'b11, 1'b1, BASE - 32'h4,   1'b0};
    vecs[7] = '{2'b10, 1'b1, BASE + 32'h402, 1'b1};

    do_reset();

    // Address decode table: observe the entry two cycles after the address phase.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      applyStimulus(vecs[i].tr, vecs[i].wr, vecs[i].addr, 32'h0, 12'd100);
      applyStimulus(2'b00, 1'b0, 32'h0, 32'hA5A5_0000 + 32'(i), 12'd100);
      applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 12'd100);
`ifdef SPRITE_WRITE_DEFER_EN
      compare($sformatf("decode%0d_level", i), obs_level, vecs[i].exp_hit ? LW'(1) : LW'(0));
`else
      compare($sformatf("decode%0d_wr", i), obs_wr, vecs[i].exp_hit);
`endif
    end

`ifdef SPRITE_WRITE_DEFER_EN
    // Single write held outside vblank, released once row 480 is reached.
    do_reset();
    applyStimulus(2'b10, 1'b1, BASE + 32'h10, 32'h0, 12'd100);
    applyStimulus(2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF, 12'd100);
    idle(2, 12'd100);
    compare("single_level", obs_level, LW'(1));
    idle(3, 12'd479);
    compare("single_479_strobes", 41'(seen.size()), 41'd0);
    idle(3, 12'd480);
    compare("single_strobes", 41'(seen.size()), 41'd1);
    if (seen.size() > 0) compare("single_entry", seen[0], {9'h004, 32'hDEAD_BEEF});

    // Nine back-to-back writes into an eight-deep buffer.
    do_reset();
    for (int i = 0; i < 9; i++)
      applyStimulus(i == 0 ? 2'b10 : 2'b11, 1'b1, BASE + 32'(4 * i), i == 0 ? 32'h0 : pat(i - 1), 12'd100);
    applyStimulus(2'b00, 1'b0, 32'h0, pat(8), 12'd100);
    idle(2, 12'd100);
    compare("b2b_level", obs_level, LW'(8));
    compare("b2b_overflow", obs_ovf, 1'b1);
    idle(12, 12'd480);
    compare("b2b_count", 41'(seen.size()), 41'd8);
    for (int k = 0; k < 8 && k < seen.size(); k++)
      compare($sformatf("b2b_entry%0d", k), seen[k], {9'(k), pat(k)});

    // Full buffer: the ninth entry lands in the same cycle as the first pop.
    do_reset();
    for (int i = 0; i < 9; i++)
      applyStimulus(i == 0 ? 2'b10 : 2'b11, 1'b1, BASE + 32'(4 * i), i == 0 ? 32'h0 : pat(i - 1), 12'd100);
    applyStimulus(2'b00, 1'b0, 32'h0, pat(8), 12'd480);
    idle(12, 12'd480);
    compare("fullpop_count", 41'(seen.size()), 41'd9);
    compare("fullpop_overflow", obs_ovf, 1'b0);
    for (int k = 0; k < 9 && k < seen.size(); k++)
      compare($sformatf("fullpop_entry%0d", k), seen[k], {9'(k), pat(k)});

    // Leaving vblank mid-drain keeps the rest for the next blank.
    do_reset();
    for (int i = 0; i < 4; i++)
      applyStimulus(2'b10, 1'b1, BASE + 32'h40 + 32'(4 * i), i == 0 ? 32'h0 : pat(i - 1), 12'd100);
    applyStimulus(2'b00, 1'b0, 32'h0, pat(3), 12'd100);
    idle(1, 12'd100);
    idle(2, 12'd480);
    idle(4, 12'd100);
    compare("middrain_count", 41'(seen.size()), 41'd2);
    compare("middrain_level", obs_level, LW'(2));
    idle(4, 12'd480);
    compare("middrain_total", 41'(seen.size()), 41'd4);
    for (int k = 0; k < 4 && k < seen.size(); k++)
      compare($sformatf("middrain_entry%0d", k), seen[k], {9'h010 + 9'(k), pat(k)});
`else
    // Pass-through: strobe exactly two cycles after the address phase.
    do_reset();
    applyStimulus(2'b10, 1'b1, BASE + 32'h10, 32'h0, 12'd200);
    applyStimulus(2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF, 12'd200);
    compare("direct_n1_wr", obs_wr, 1'b0);
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 12'd200);
    compare("direct_n2_wr", obs_wr, 1'b1);
    compare("direct_level", obs_level, LW'(0));
    if (seen.size() > 0) compare("direct_entry", seen[0], {9'h004, 32'hDEAD_BEEF});
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 12'd200);
    compare("direct_n3_wr", obs_wr, 1'b0);

    do_reset();
    for (int i = 0; i < 3; i++)
      applyStimulus(i == 0 ? 2'b10 : 2'b11, 1'b1, BASE + 32'(4 * i), i == 0 ? 32'h0 : pat(i - 1), 12'd600);
    applyStimulus(2'b00, 1'b0, 32'h0, pat(2), 12'd600);
    idle(2, 12'd600);
    compare("direct_b2b_count", 41'(seen.size()), 41'd3);
    for (int k = 0; k < 3 && k < seen.size(); k++)
      compare($sformatf("direct_b2b_entry%0d", k), seen[k], {9'(k), pat(k)});
`endif

    // Reset during a data phase with earlier entries outstanding.
    do_reset();
    for (int i = 0; i < 4; i++)
      applyStimulus(i == 0 ? 2'b10 : 2'b11, 1'b1, BASE + 32'h20 + 32'(4 * i), i == 0 ? 32'h0 : pat(i - 1), 12'd100);
    do_reset();
    idle(6, 12'd480);
    compare("rstmid_strobes", 41'(seen.size()), 41'd0);
    compare("rstmid_level", obs_level, LW'(0));
    compare("rstmid_overflow", obs_ovf, 1'b0);

    // Randomized traffic with occasional resets, checked cycle by cycle.
    begin
      logic [11:0] cur_row;
      logic [31:0] a;
      int          r;
      do_reset();
      cur_row = 12'd100;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        if (cyc % 16 == 0)
          cur_row = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(480, 490))
                                                 : 12'($urandom_range(470, 479));
        if (cyc % 700 == 699) do_reset();
        r = $urandom_range(0, 9);
        if (r < 7)       a = BASE + 32'($urandom_range(0, 2047));
        else if (r == 7) a = BASE + 32'h800 + 32'($urandom_range(0, 2047));
        else             a = $urandom;
        applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, a, $urandom, cur_row);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
